// File: rtl/combo_lock.sv
// Serial combination lock with a failed-attempt counter, a timed alarm lockout, and registered outputs.
// Optional in-field code reprogramming while open is enabled by defining COMBO_LOCK_PROG_EN.
module combo_lock #(
  parameter int                  CODE_LEN       = 6,
  parameter logic [CODE_LEN-1:0] CODE           = 6'b011001,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              one,
  input  logic                              zero,
  input  logic                              st,
`ifdef COMBO_LOCK_PROG_EN
  input  logic                              prog,
`endif
  output logic                              op,
  output logic                              alarm,
  output logic [$clog2(CODE_LEN+1)-1:0]     cnt,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fails
);

  localparam int CW = $clog2(CODE_LEN+1);
  localparam int FW = $clog2(MAX_FAILS+1);
  localparam int TW = $clog2(LOCKOUT_CYCLES+1);

  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} state_t;

  state_t              state, state_n;
  logic                st_q;
  logic                pbit, pbit_n;
  logic                pvalid, pvalid_n;
  logic [CODE_LEN-1:0] entry, entry_n, entry_sh;
  logic [TW-1:0]       timer, timer_n;
  logic [CW-1:0]       cnt_n;
  logic [FW-1:0]       fails_n;
  logic                commit, press;
  logic [CODE_LEN-1:0] code_q;
`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_n;
`else
  assign code_q = CODE;
`endif

  assign commit   = st & ~st_q;
  assign press    = one ^ zero;
  assign entry_sh = (entry << 1) | CODE_LEN'(pbit);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    fails_n  = fails;
    timer_n  = timer;
    pbit_n   = pbit;
    pvalid_n = pvalid;
    entry_n  = entry;
`ifdef COMBO_LOCK_PROG_EN
    code_n   = code_q;
`endif
    case (state)
      ENTRY: begin
        if (commit && pvalid) begin
          entry_n  = entry_sh;
          pvalid_n = 1'b0;
          if (cnt == CW'(CODE_LEN-1)) begin
            cnt_n = '0;
            if (entry_sh == code_q) begin
              state_n = OPEN;
              fails_n = '0;
            end else if (int'(fails) + 1 < MAX_FAILS) begin
              fails_n = fails + FW'(1);
            end else begin
              state_n = LOCKOUT;
              timer_n = TW'(LOCKOUT_CYCLES);
              fails_n = FW'(MAX_FAILS);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        // A press in the commit cycle becomes the next pending bit, unless we just left ENTRY.
        if (press && state_n == ENTRY) begin
          pbit_n   = one;
          pvalid_n = 1'b1;
        end
      end
      OPEN: begin
        pvalid_n = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
        if (prog) begin
          pvalid_n = pvalid;
          if (commit && pvalid) begin
            entry_n  = entry_sh;
            pvalid_n = 1'b0;
            if (cnt == CW'(CODE_LEN-1)) begin
              cnt_n  = '0;
              code_n = entry_sh;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          if (press) begin
            pbit_n   = one;
            pvalid_n = 1'b1;
          end
        end else begin
          cnt_n = '0;
          if (commit) state_n = ENTRY;
        end
`else
        if (commit) state_n = ENTRY;
`endif
      end
      LOCKOUT: begin
        pvalid_n = 1'b0;
        if (timer == TW'(1)) begin
          state_n = ENTRY;
          fails_n = '0;
          timer_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ENTRY;
      op     <= 1'b0;
      alarm  <= 1'b0;
      cnt    <= '0;
      fails  <= '0;
      st_q   <= 1'b0;
      pbit   <= 1'b0;
      pvalid <= 1'b0;
      entry  <= '0;
      timer  <= '0;
`ifdef COMBO_LOCK_PROG_EN
      code_q <= CODE;
`endif
    end else begin
      state  <= state_n;
      op     <= (state_n == OPEN);
      alarm  <= (state_n == LOCKOUT);
      cnt    <= cnt_n;
      fails  <= fails_n;
      st_q   <= st;
      pbit   <= pbit_n;
      pvalid <= pvalid_n;
      entry  <= entry_n;
      timer  <= timer_n;
`ifdef COMBO_LOCK_PROG_EN
      code_q <= code_n;
`endif
    end
  end

endmodule
